racket_control: RTL and testbench

Racket position generator for the pong game: turns player up/down buttons into the racket Y positions consumed by the ball FSM, which reads them as `pos_of_player_1` and `pos_of_player_2`.

- Positions update once per video frame, with frame-count acceleration and clamping to the visible area.
- In single-player mode, an optional tracker drives racket 2 from the ball's Y position.
- Sits between the input synchroniser/keyboard layer and the ball FSM, in the 65 MHz XGA domain.

---
 rtl/game_pkg.sv | 13 +
 rtl/racket_axis.sv | 74 +++++++
 rtl/racket_control.sv | 114 +++++++++++
 tb/tb_racket_control.sv | 182 ++++++++++++++++++
 4 files changed

// File: rtl/game_pkg.sv
// Shared pong constants and game-screen mode encoding.
// Pure declarations: no logic, no latency, no flow control.
package game_pkg;

  localparam int Y_SCREEN         = 768;
  localparam int Y_SIZE_OF_RACKET = 80;
  localparam int SIZE_OF_BALL     = 15;
  localparam int POS_MAX          = Y_SCREEN - Y_SIZE_OF_RACKET;
  localparam int CENTER           = POS_MAX / 2;

  typedef enum logic [1:0] {IDLE, SINGLE, MULTI} mode_t;

endpackage

// File: rtl/racket_axis.sv
// One racket axis: button synchroniser, accelerating velocity, clamped position.
// Latency: 2 sync cycles, then position registered on the edge that samples end_of_frame.
// No backpressure: force_center beats load_en, which beats button motion.
module racket_axis #(
  parameter int POS_MAX = game_pkg::POS_MAX,
  parameter int CENTER  = game_pkg::CENTER,
  parameter int V_START = 2,
  parameter int V_MAX   = 12
) (
  input  logic       clk65MHz,
  input  logic       rst_n,
  input  logic       end_of_frame,
  input  logic       up,
  input  logic       down,
  input  logic       force_center,
  input  logic       load_en,
  input  logic [9:0] load_pos,
  output logic [9:0] pos
);
  import game_pkg::*;

  logic [1:0]  up_sync, dn_sync;
  logic        up_s, dn_s;
  logic [10:0] pos_q, pos_nxt, vel_q, vel_nxt, step;
  logic        dir_q, dir_nxt;

  always_ff @(posedge clk65MHz) begin
    if (!rst_n) begin
      up_sync <= 2'b00;
      dn_sync <= 2'b00;
      pos_q   <= 11'(CENTER);
      vel_q   <= 11'd0;
      dir_q   <= 1'b0;
    end else begin
      up_sync <= {up_sync[0], up};
      dn_sync <= {dn_sync[0], down};
      pos_q   <= pos_nxt;
      vel_q   <= vel_nxt;
      dir_q   <= dir_nxt;
    end
  end

  // Both buttons held cancel out.
  assign up_s = up_sync[1] & ~dn_sync[1];
  assign dn_s = dn_sync[1] & ~up_sync[1];

  always_comb begin
    step    = (vel_q == 11'd0 || dir_q != dn_s) ? 11'(V_START) : vel_q;
    pos_nxt = pos_q;
    vel_nxt = vel_q;
    dir_nxt = dir_q;
    if (force_center) begin
      pos_nxt = 11'(CENTER);
      vel_nxt = 11'd0;
    end else if (load_en) begin
      pos_nxt = {1'b0, load_pos};
      vel_nxt = 11'd0;
    end else if (end_of_frame) begin
      if (dn_s || up_sync[1] & ~dn_sync[1]) begin
        if (dn_s)
          pos_nxt = (pos_q + step > 11'(POS_MAX)) ? 11'(POS_MAX) : pos_q + step;
        else
          pos_nxt = (step > pos_q) ? 11'd0 : pos_q - step;
        vel_nxt = (step >= 11'(V_MAX)) ? 11'(V_MAX) : step + 11'd1;
        dir_nxt = dn_s;
      end else begin
        vel_nxt = 11'd0;
      end
    end
  end

  assign pos = pos_q[9:0];

endmodule

// File: rtl/racket_control.sv
// Racket Y positions for both players; optional single-player tracker under RACKET_AI_EN.
// Latency: positions update 1 cycle after end_of_frame; IDLE centres on the next edge.
// No backpressure: outputs are registered and held stable for the rest of the frame.
module racket_control #(
  parameter int Y_SCREEN         = game_pkg::Y_SCREEN,
  parameter int Y_SIZE_OF_RACKET = game_pkg::Y_SIZE_OF_RACKET,
  parameter int SIZE_OF_BALL     = game_pkg::SIZE_OF_BALL,
  parameter int V_START          = 2,
  parameter int V_MAX            = 12,
  parameter int AI_STEP          = 4
) (
  input  logic        clk65MHz,
  input  logic        rst_n,
  input  logic        end_of_frame,
  input  logic        screen_idle,
  input  logic        screen_single,
  input  logic        screen_multi,
  input  logic        p1_up,
  input  logic        p1_down,
  input  logic        p2_up,
  input  logic        p2_down,
  input  logic [10:0] y_pos_of_ball,
  output logic [9:0]  pos_of_player_1,
  output logic [9:0]  pos_of_player_2
);
  import game_pkg::*;

  localparam int PMAX = Y_SCREEN - Y_SIZE_OF_RACKET;
  localparam int PCTR = PMAX / 2;

  mode_t      mode_q, mode_nxt;
  logic       center1, center2, load2;
  logic [9:0] load_pos2;

  always_ff @(posedge clk65MHz) begin
    if (!rst_n) mode_q <= IDLE;
    else        mode_q <= mode_nxt;
  end

  // Rules key off the incoming mode so a select change on a frame pulse takes effect at once.
  always_comb begin
    mode_nxt = mode_q;
    if (screen_idle)        mode_nxt = IDLE;
    else if (screen_multi)  mode_nxt = MULTI;
    else if (screen_single) mode_nxt = SINGLE;
    else                    mode_nxt = IDLE;
  end

`ifdef RACKET_AI_EN
  logic [10:0] ball_c, rack_c, ai_pos;

  always_comb begin
    ball_c = y_pos_of_ball + 11'(SIZE_OF_BALL / 2);
    rack_c = {1'b0, pos_of_player_2} + 11'(Y_SIZE_OF_RACKET / 2);
    ai_pos = {1'b0, pos_of_player_2};
    if (ball_c > rack_c + 11'(AI_STEP))
      ai_pos = ({1'b0, pos_of_player_2} + 11'(AI_STEP) > 11'(PMAX)) ?
               11'(PMAX) : {1'b0, pos_of_player_2} + 11'(AI_STEP);
    else if (ball_c + 11'(AI_STEP) < rack_c)
      ai_pos = (pos_of_player_2 < 10'(AI_STEP)) ?
               11'd0 : {1'b0, pos_of_player_2} - 11'(AI_STEP);
  end
`else
  logic ai_unused;
  assign ai_unused = ^{y_pos_of_ball, 11'(SIZE_OF_BALL), 11'(AI_STEP)};
`endif

  always_comb begin
    center1   = 1'b0;
    center2   = 1'b0;
    load2     = 1'b0;
    load_pos2 = pos_of_player_2;
    case (mode_nxt)
      IDLE: begin
        center1 = 1'b1;
        center2 = 1'b1;
      end
      SINGLE: begin
`ifdef RACKET_AI_EN
        load2     = end_of_frame;
        load_pos2 = ai_pos[9:0];
`else
        center2   = 1'b1;
`endif
      end
      default: ;
    endcase
  end

  racket_axis #(.POS_MAX(PMAX), .CENTER(PCTR), .V_START(V_START), .V_MAX(V_MAX)) u_axis1 (
    .clk65MHz     (clk65MHz),
    .rst_n        (rst_n),
    .end_of_frame (end_of_frame),
    .up           (p1_up),
    .down         (p1_down),
    .force_center (center1),
    .load_en      (1'b0),
    .load_pos     (10'd0),
    .pos          (pos_of_player_1)
  );

  racket_axis #(.POS_MAX(PMAX), .CENTER(PCTR), .V_START(V_START), .V_MAX(V_MAX)) u_axis2 (
    .clk65MHz     (clk65MHz),
    .rst_n        (rst_n),
    .end_of_frame (end_of_frame),
    .up           (p2_up),
    .down         (p2_down),
    .force_center (center2),
    .load_en      (load2),
    .load_pos     (load_pos2),
    .pos          (pos_of_player_2)
  );

endmodule

// File: tb/tb_racket_control.sv
// Directed self-checking bench for racket_control; inputs driven on negedge, outputs sampled on negedge.
module tb_racket_control;

  logic        clk65MHz = 1'b0;
  logic        rst_n = 1'b0;
  logic        end_of_frame = 1'b0;
  logic        screen_idle = 1'b0, screen_single = 1'b0, screen_multi = 1'b0;
  logic        p1_up = 1'b0, p1_down = 1'b0, p2_up = 1'b0, p2_down = 1'b0;
  logic [10:0] y_pos_of_ball = 11'd0;
  logic [9:0]  pos_of_player_1, pos_of_player_2;

  int checks = 0;
  int passes = 0;

  always #5 clk65MHz = ~clk65MHz;

  racket_control dut (
    .clk65MHz        (clk65MHz),
    .rst_n           (rst_n),
    .end_of_frame    (end_of_frame),
    .screen_idle     (screen_idle),
    .screen_single   (screen_single),
    .screen_multi    (screen_multi),
    .p1_up           (p1_up),
    .p1_down         (p1_down),
    .p2_up           (p2_up),
    .p2_down         (p2_down),
    .y_pos_of_ball   (y_pos_of_ball),
    .pos_of_player_1 (pos_of_player_1),
    .pos_of_player_2 (pos_of_player_2)
  );

  task automatic tick(input int n);
    repeat (n) @(negedge clk65MHz);
  endtask

  task automatic frame();
    end_of_frame = 1'b1;
    @(negedge clk65MHz);
    end_of_frame = 1'b0;
  endtask

  task automatic test_reset();
    tick(3);
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL reset_p1 got=%0d exp=344", pos_of_player_1); else passes++;
    checks++; if (pos_of_player_2 !== 10'd344) $display("FAIL reset_p2 got=%0d exp=344", pos_of_player_2); else passes++;
    rst_n = 1'b1;
    screen_multi = 1'b1;
    tick(2);
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL multi_entry_p1 got=%0d exp=344", pos_of_player_1); else passes++;
  endtask

  task automatic test_no_buttons();
    for (int k = 0; k < 10; k++) begin
      frame();
      tick(2);
      checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL idle_frame_p1 k=%0d got=%0d exp=344", k, pos_of_player_1); else passes++;
      checks++; if (pos_of_player_2 !== 10'd344) $display("FAIL idle_frame_p2 k=%0d got=%0d exp=344", k, pos_of_player_2); else passes++;
    end
  endtask

  task automatic test_p1_up();
    int exp_pos[3];
    int prev;
    exp_pos = '{342, 339, 335};
    prev = 344;
    p1_up = 1'b1;
    tick(3);
    for (int k = 0; k < 3; k++) begin
      end_of_frame = 1'b1;
      checks++; if (pos_of_player_1 !== 10'(prev)) $display("FAIL up_before_pulse k=%0d got=%0d exp=%0d", k, pos_of_player_1, prev); else passes++;
      @(negedge clk65MHz);
      end_of_frame = 1'b0;
      checks++; if (pos_of_player_1 !== 10'(exp_pos[k])) $display("FAIL up_after_pulse k=%0d got=%0d exp=%0d", k, pos_of_player_1, exp_pos[k]); else passes++;
      prev = exp_pos[k];
      tick(2);
    end
  endtask

  task automatic test_both_and_reset();
    p1_down = 1'b1;
    tick(3);
    for (int k = 0; k < 5; k++) begin
      frame();
      checks++; if (pos_of_player_1 !== 10'd335) $display("FAIL both_held k=%0d got=%0d exp=335", k, pos_of_player_1); else passes++;
    end
    rst_n = 1'b0;
    @(negedge clk65MHz);
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL midhold_reset got=%0d exp=344", pos_of_player_1); else passes++;
    rst_n = 1'b1;
    p1_down = 1'b0;
    tick(3);
    frame();
    checks++; if (pos_of_player_1 !== 10'd342) $display("FAIL no_residual_vel got=%0d exp=342", pos_of_player_1); else passes++;
    p1_up = 1'b0;
  endtask

  task automatic test_p2_clamp();
    int exp_pos[5];
    exp_pos = '{682, 685, 688, 688, 688};
    p2_down = 1'b1;
    tick(3);
    repeat (32) frame();
    checks++; if (pos_of_player_2 !== 10'd673) $display("FAIL ramp_32 got=%0d exp=673", pos_of_player_2); else passes++;
    p2_down = 1'b0; tick(3); frame();
    p2_down = 1'b1; tick(3); frame();
    checks++; if (pos_of_player_2 !== 10'd675) $display("FAIL repress_v_start got=%0d exp=675", pos_of_player_2); else passes++;
    p2_down = 1'b0; tick(3); frame();
    p2_down = 1'b1; tick(3); frame(); frame();
    checks++; if (pos_of_player_2 !== 10'd680) $display("FAIL reach_680 got=%0d exp=680", pos_of_player_2); else passes++;
    p2_down = 1'b0; tick(3); frame();
    p2_down = 1'b1; tick(3);
    for (int k = 0; k < 5; k++) begin
      frame();
      checks++; if (pos_of_player_2 !== 10'(exp_pos[k])) $display("FAIL clamp_down k=%0d got=%0d exp=%0d", k, pos_of_player_2, exp_pos[k]); else passes++;
    end
    p2_down = 1'b0;
  endtask

  task automatic test_mode_change_eof();
    p1_down = 1'b1;
    tick(3);
    screen_idle = 1'b1;
    frame();
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL idle_on_eof_p1 got=%0d exp=344", pos_of_player_1); else passes++;
    checks++; if (pos_of_player_2 !== 10'd344) $display("FAIL idle_on_eof_p2 got=%0d exp=344", pos_of_player_2); else passes++;
    tick(2);
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL idle_hold got=%0d exp=344", pos_of_player_1); else passes++;
    screen_idle = 1'b0;
    frame();
    checks++; if (pos_of_player_1 !== 10'd346) $display("FAIL multi_on_eof got=%0d exp=346", pos_of_player_1); else passes++;
  endtask

  task automatic test_idle_no_frame();
    tick(2);
    frame();
    checks++; if (pos_of_player_1 !== 10'd349) $display("FAIL accel_down got=%0d exp=349", pos_of_player_1); else passes++;
    screen_idle = 1'b1;
    @(negedge clk65MHz);
    checks++; if (pos_of_player_1 !== 10'd344) $display("FAIL idle_no_pulse got=%0d exp=344", pos_of_player_1); else passes++;
    screen_idle = 1'b0;
    p1_down = 1'b0;
  endtask

  task automatic test_single();
    int exp2;
    screen_multi = 1'b0;
    screen_single = 1'b1;
    y_pos_of_ball = 11'd500;
    p2_down = 1'b1;
    p1_up = 1'b1;
    tick(3);
    for (int k = 1; k <= 35; k++) begin
      frame();
`ifdef RACKET_AI_EN
      exp2 = (344 + 4 * k > 464) ? 464 : 344 + 4 * k;
`else
      exp2 = 344;
`endif
      checks++; if (pos_of_player_2 !== 10'(exp2)) $display("FAIL single_p2 k=%0d got=%0d exp=%0d", k, pos_of_player_2, exp2); else passes++;
      if (k == 1) begin
        checks++; if (pos_of_player_1 !== 10'd342) $display("FAIL single_p1_manual got=%0d exp=342", pos_of_player_1); else passes++;
      end
    end
    p1_up = 1'b0;
    p2_down = 1'b0;
  endtask

  initial begin
    test_reset();
    test_no_buttons();
    test_p1_up();
    test_both_and_reset();
    test_p2_clamp();
    test_mode_change_eof();
    test_idle_no_frame();
    test_single();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
